// File: rtl/hkr_bus_pkg.sv
// =============================================================================
// Module : hkr_bus_pkg
// Brief  : Shared types and helpers for the instruction-bus wait-request bridge.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

package hkr_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } ibus_bridge_state_t;

    localparam int WORD_ADDR_W = 30;

    // Watchdog counter width: enough for the limit, clamped to 8..16 bits.
    function automatic int wd_width(input int cycles);
        int w;
        w = $clog2(cycles);
        if (w < 8)  w = 8;
        if (w > 16) w = 16;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus_watchdog.sv
// =============================================================================
// Module : bus_watchdog
// Brief  : Load/enable up-counter that flags expiry at LIMIT-1 while enabled.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module bus_watchdog
    import hkr_bus_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LIMIT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/ibus_wait_bridge.sv
// =============================================================================
// Module : ibus_wait_bridge
// Brief  : CPU instruction bus to wait-request slave bridge with a one-entry
//          last-fetch buffer. Optional watchdog: IBUS_BRIDGE_TIMEOUT_EN.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module ibus_wait_bridge
    import hkr_bus_pkg::*;
#(
    parameter int HIT_BUF        = 1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ibus_addr,
    input  logic [3:0]  ibus_byte_en,
    input  logic        ibus_read,
    input  logic        ibus_write,
    input  logic [31:0] ibus_write_data,
    output logic [31:0] ibus_read_data,
    output logic        ibus_stall,
    output logic [31:0] av_address,
    output logic [3:0]  av_byteenable,
    output logic        av_read,
    output logic        av_write,
    output logic [31:0] av_writedata,
    input  logic [31:0] av_readdata,
    input  logic        av_waitrequest,
    output logic        bus_error
);

    localparam bit USE_BUF = (HIT_BUF != 0);

    ibus_bridge_state_t     state_q, state_d;
    logic [WORD_ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_ADDR_W-1:0] tag_q, tag_d;
    logic [3:0]             be_q, be_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [31:0]            data_q, data_d;
    logic [31:0]            buf_q, buf_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   av_read_q, av_read_d;
    logic                   av_write_q, av_write_d;
    logic                   valid_q, valid_d;
    logic                   drain_q, drain_d;
    logic                   bus_error_q, bus_error_d;

    logic        req;
    logic        hit;
    logic        stall;
    logic [31:0] rd_out;
    logic        wd_load;
    logic        wd_en;
    logic        wd_expire;

    assign req = ibus_read | ibus_write;
    assign hit = USE_BUF && ibus_read && valid_q && (tag_q == ibus_addr[31:2]);

`ifdef IBUS_BRIDGE_TIMEOUT_EN
    bus_watchdog #(
        .WIDTH (wd_width(TIMEOUT_CYCLES)),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (wd_load),
        .en_i     (wd_en),
        .expire_o (wd_expire)
    );
`else
    logic unused_wd;
    assign wd_expire = 1'b0;
    assign unused_wd = wd_load ^ wd_en ^ (TIMEOUT_CYCLES > 0);
`endif

    // Byte offset is irrelevant: the slave is always addressed by word.
    logic unused_addr_bits;
    assign unused_addr_bits = ^ibus_addr[1:0];

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        tag_d       = tag_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        data_d      = data_q;
        buf_d       = buf_q;
        rdata_d     = rdata_q;
        av_read_d   = av_read_q;
        av_write_d  = av_write_q;
        valid_d     = valid_q;
        drain_d     = drain_q;
        bus_error_d = 1'b0;
        stall       = 1'b0;
        rd_out      = rdata_q;
        wd_load     = 1'b0;
        wd_en       = 1'b0;

        case (state_q)
            IDLE: begin
                wd_load = 1'b1;
                if (hit) begin
                    rd_out  = buf_q;
                    rdata_d = buf_q;
                end else if (req) begin
                    stall      = 1'b1;
                    addr_d     = ibus_addr[31:2];
                    be_d       = ibus_byte_en;
                    wdata_d    = ibus_write_data;
                    av_read_d  = ibus_read;
                    av_write_d = ibus_write;
                    if (ibus_write) begin
                        valid_d = 1'b0;
                    end
                    state_d = BUS;
                end
            end

            BUS: begin
                wd_en = 1'b1;
                // A dropped request (pipeline flush) releases the CPU at once,
                // but the slave transaction must still run to completion.
                stall = req;
                if (!req) begin
                    drain_d = 1'b1;
                end
                if (!av_waitrequest) begin
                    av_read_d  = 1'b0;
                    av_write_d = 1'b0;
                    data_d     = av_readdata;
                    drain_d    = 1'b0;
                    if (av_read_q && USE_BUF) begin
                        valid_d = 1'b1;
                        tag_d   = addr_q;
                        buf_d   = av_readdata;
                    end
                    state_d = (drain_q || !req) ? IDLE : DONE;
                end else if (wd_expire) begin
                    av_read_d   = 1'b0;
                    av_write_d  = 1'b0;
                    data_d      = 32'h0;
                    drain_d     = 1'b0;
                    bus_error_d = 1'b1;
                    state_d     = DONE;
                end
            end

            DONE: begin
                rd_out  = data_q;
                rdata_d = data_q;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            tag_q       <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            data_q      <= '0;
            buf_q       <= '0;
            rdata_q     <= '0;
            av_read_q   <= 1'b0;
            av_write_q  <= 1'b0;
            valid_q     <= 1'b0;
            drain_q     <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            tag_q       <= tag_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            data_q      <= data_d;
            buf_q       <= buf_d;
            rdata_q     <= rdata_d;
            av_read_q   <= av_read_d;
            av_write_q  <= av_write_d;
            valid_q     <= valid_d;
            drain_q     <= drain_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign ibus_stall     = stall;
    assign ibus_read_data = rd_out;
    assign av_address     = {addr_q, 2'b00};
    assign av_byteenable  = be_q;
    assign av_read        = av_read_q;
    assign av_write       = av_write_q;
    assign av_writedata   = wdata_q;
    assign bus_error      = bus_error_q;

endmodule

`default_nettype wire

// File: tb/tb_ibus_wait_bridge.sv
// =============================================================================
// Module : tb_ibus_wait_bridge
// Brief  : Directed vector bench for ibus_wait_bridge (watchdog part runs only
//          when IBUS_BRIDGE_TIMEOUT_EN is defined).
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module tb_ibus_wait_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ibus_addr;
    logic [3:0]  ibus_byte_en;
    logic        ibus_read;
    logic        ibus_write;
    logic [31:0] ibus_write_data;
    logic [31:0] ibus_read_data;
    logic        ibus_stall;
    logic [31:0] av_address;
    logic [3:0]  av_byteenable;
    logic        av_read;
    logic        av_write;
    logic [31:0] av_writedata;
    logic [31:0] av_readdata;
    logic        av_waitrequest;
    logic        bus_error;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

`ifdef IBUS_BRIDGE_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
`else
    localparam int TB_TIMEOUT = 256;
`endif

    ibus_wait_bridge #(
        .HIT_BUF        (1),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ibus_addr       (ibus_addr),
        .ibus_byte_en    (ibus_byte_en),
        .ibus_read       (ibus_read),
        .ibus_write      (ibus_write),
        .ibus_write_data (ibus_write_data),
        .ibus_read_data  (ibus_read_data),
        .ibus_stall      (ibus_stall),
        .av_address      (av_address),
        .av_byteenable   (av_byteenable),
        .av_read         (av_read),
        .av_write        (av_write),
        .av_writedata    (av_writedata),
        .av_readdata     (av_readdata),
        .av_waitrequest  (av_waitrequest),
        .bus_error       (bus_error)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        wreq;
        logic [31:0] sdata;
        logic        e_stall;
        logic        e_avr;
        logic        e_avw;
        logic [31:0] e_addr;
        logic        chk_rd;
        logic [31:0] e_rd;
    } vec_t;

    localparam logic [31:0] A0 = 32'h8000_0000;
    localparam logic [31:0] A1 = 32'h8000_0004;
    localparam logic [31:0] A2 = 32'h8000_0010;
    localparam logic [31:0] A3 = 32'h8000_0100;
    localparam logic [31:0] AX = 32'h8000_0040;
    localparam logic [31:0] D0 = 32'h3C08_0001;
    localparam logic [31:0] D1 = 32'h1234_5678;
    localparam logic [31:0] D2 = 32'hCAFE_F00D;
    localparam logic [31:0] D3 = 32'h0BAD_F00D;
    localparam logic [31:0] D4 = 32'h2402_0005;
    localparam logic [31:0] D5 = 32'h8C42_0010;
    localparam logic [31:0] D6 = 32'hAC43_0004;
    localparam logic [31:0] D7 = 32'h0800_0123;
    localparam logic [31:0] WD = 32'hDEAD_BEEF;

    function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [3:0] be, input logic [31:0] wdata,
                                input logic wreq, input logic [31:0] sdata,
                                input logic e_stall, input logic e_avr, input logic e_avw,
                                input logic [31:0] e_addr, input logic chk_rd,
                                input logic [31:0] e_rd);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.be = be; v.wdata = wdata;
        v.wreq = wreq; v.sdata = sdata; v.e_stall = e_stall; v.e_avr = e_avr;
        v.e_avw = e_avw; v.e_addr = e_addr; v.chk_rd = chk_rd; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after posedge, check at negedge.
    task automatic step(input vec_t v, input string tag);
        ibus_read       = v.rd;
        ibus_write      = v.wr;
        ibus_addr       = v.addr;
        ibus_byte_en    = v.be;
        ibus_write_data = v.wdata;
        av_waitrequest  = v.wreq;
        av_readdata     = v.sdata;
        @(negedge clk);
        chk({tag, ".stall"},  {31'b0, ibus_stall}, {31'b0, v.e_stall});
        chk({tag, ".av_read"}, {31'b0, av_read},   {31'b0, v.e_avr});
        chk({tag, ".av_write"}, {31'b0, av_write}, {31'b0, v.e_avw});
        chk({tag, ".av_address"}, av_address, v.e_addr);
        chk({tag, ".bus_error"}, {31'b0, bus_error}, 32'h0);
        if (v.chk_rd) begin
            chk({tag, ".read_data"}, ibus_read_data, v.e_rd);
        end
        if (v.e_avw) begin
            chk({tag, ".av_byteenable"}, {28'b0, av_byteenable}, {28'b0, v.be});
            chk({tag, ".av_writedata"}, av_writedata, v.wdata);
        end
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[24];

    initial begin
        tbl[0]  = mk(1, 0, A0, 4'hF, 0,  0, D0, 1, 0, 0, 32'h0, 0, 0);
        tbl[1]  = mk(1, 0, A0, 4'hF, 0,  0, D0, 1, 1, 0, A0, 0, 0);
        tbl[2]  = mk(1, 0, A0, 4'hF, 0,  0, D0, 0, 0, 0, A0, 1, D0);
        tbl[3]  = mk(1, 0, A0, 4'hF, 0,  0, 0,  0, 0, 0, A0, 1, D0);
        tbl[4]  = mk(0, 0, A0, 4'hF, 0,  0, 0,  0, 0, 0, A0, 1, D0);
        tbl[5]  = mk(0, 1, A0, 4'h3, WD, 0, 0,  1, 0, 0, A0, 0, 0);
        tbl[6]  = mk(0, 1, A0, 4'h3, WD, 0, 0,  1, 0, 1, A0, 0, 0);
        tbl[7]  = mk(0, 1, A0, 4'h3, WD, 0, 0,  0, 0, 0, A0, 0, 0);
        tbl[8]  = mk(1, 0, A0, 4'hF, 0,  0, D1, 1, 0, 0, A0, 0, 0);
        tbl[9]  = mk(1, 0, A0, 4'hF, 0,  0, D1, 1, 1, 0, A0, 0, 0);
        tbl[10] = mk(1, 0, A0, 4'hF, 0,  0, D1, 0, 0, 0, A0, 1, D1);
        tbl[11] = mk(1, 0, A1, 4'hF, 0,  1, 0,  1, 0, 0, A0, 0, 0);
        tbl[12] = mk(1, 0, A1, 4'hF, 0,  1, 0,  1, 1, 0, A1, 0, 0);
        tbl[13] = mk(1, 0, A1, 4'hF, 0,  1, 0,  1, 1, 0, A1, 0, 0);
        tbl[14] = mk(1, 0, A1, 4'hF, 0,  1, 0,  1, 1, 0, A1, 0, 0);
        tbl[15] = mk(1, 0, A1, 4'hF, 0,  1, 0,  1, 1, 0, A1, 0, 0);
        tbl[16] = mk(1, 0, A1, 4'hF, 0,  0, D2, 1, 1, 0, A1, 0, 0);
        tbl[17] = mk(1, 0, A1, 4'hF, 0,  0, D2, 0, 0, 0, A1, 1, D2);
        tbl[18] = mk(0, 0, A1, 4'hF, 0,  0, 0,  0, 0, 0, A1, 1, D2);
        tbl[19] = mk(1, 0, A1, 4'hF, 0,  0, 0,  0, 0, 0, A1, 1, D2);
        tbl[20] = mk(1, 0, A0, 4'hF, 0,  0, D7, 1, 0, 0, A1, 0, 0);
        tbl[21] = mk(1, 0, AX, 4'hF, 0,  0, D7, 1, 1, 0, A0, 0, 0);
        tbl[22] = mk(1, 0, AX, 4'hF, 0,  0, 0,  0, 0, 0, A0, 1, D7);
        tbl[23] = mk(0, 0, A0, 4'hF, 0,  0, 0,  0, 0, 0, A0, 1, D7);

        rst_n           = 1'b0;
        ibus_addr       = '0;
        ibus_byte_en    = '0;
        ibus_read       = 1'b0;
        ibus_write      = 1'b0;
        ibus_write_data = '0;
        av_readdata     = '0;
        av_waitrequest  = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.stall", {31'b0, ibus_stall}, 32'h0);
        chk("reset.av_read", {31'b0, av_read}, 32'h0);
        chk("reset.av_write", {31'b0, av_write}, 32'h0);
        chk("reset.av_address", av_address, 32'h0);
        chk("reset.av_byteenable", {28'b0, av_byteenable}, 32'h0);
        chk("reset.av_writedata", av_writedata, 32'h0);
        chk("reset.read_data", ibus_read_data, 32'h0);
        chk("reset.bus_error", {31'b0, bus_error}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 24; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Flush mid-transaction, then a new miss while the old read drains.
        step(mk(1, 0, A3, 4'hF, 0, 1, 0,  1, 0, 0, A0, 0, 0),  "drain1");
        step(mk(1, 0, A3, 4'hF, 0, 1, 0,  1, 1, 0, A3, 0, 0),  "drain2");
        step(mk(0, 0, A3, 4'hF, 0, 1, 0,  0, 1, 0, A3, 1, D7), "drain3");
        step(mk(1, 0, A2, 4'hF, 0, 1, 0,  1, 1, 0, A3, 0, 0),  "drain4");
        step(mk(1, 0, A2, 4'hF, 0, 0, D3, 1, 1, 0, A3, 0, 0),  "drain5");
        step(mk(1, 0, A2, 4'hF, 0, 0, D4, 1, 0, 0, A3, 0, 0),  "drain6");
        step(mk(1, 0, A2, 4'hF, 0, 0, D4, 1, 1, 0, A2, 0, 0),  "drain7");
        step(mk(1, 0, A2, 4'hF, 0, 0, 0,  0, 0, 0, A2, 1, D4), "drain8");

        // Drained read still refills the buffer.
        step(mk(1, 0, A3, 4'hF, 0, 1, 0,  1, 0, 0, A2, 0, 0),  "fill1");
        step(mk(1, 0, A3, 4'hF, 0, 1, 0,  1, 1, 0, A3, 0, 0),  "fill2");
        step(mk(0, 0, A3, 4'hF, 0, 0, D5, 0, 1, 0, A3, 1, D4), "fill3");
        step(mk(1, 0, A3, 4'hF, 0, 0, 0,  0, 0, 0, A3, 1, D5), "fill4");

        // Asynchronous reset in the middle of a slave transaction.
        step(mk(1, 0, A0, 4'hF, 0, 1, 0,  1, 0, 0, A3, 0, 0),  "arst1");
        chk("arst.av_read_before", {31'b0, av_read}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("arst.av_read_after", {31'b0, av_read}, 32'h0);
        chk("arst.av_address_after", av_address, 32'h0);
        ibus_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(mk(1, 0, A3, 4'hF, 0, 0, D6, 1, 0, 0, 32'h0, 1, 0), "arst2");
        step(mk(1, 0, A3, 4'hF, 0, 0, D6, 1, 1, 0, A3, 0, 0),    "arst3");
        step(mk(1, 0, A3, 4'hF, 0, 0, 0,  0, 0, 0, A3, 1, D6),   "arst4");
        step(mk(0, 0, A3, 4'hF, 0, 0, 0,  0, 0, 0, A3, 1, D6),   "arst5");

`ifdef IBUS_BRIDGE_TIMEOUT_EN
        begin
            int stalls;
            int pulses;
            bit done;
            stalls = 0;
            pulses = 0;
            done   = 1'b0;
            ibus_read      = 1'b1;
            ibus_addr      = A0;
            av_waitrequest = 1'b1;
            av_readdata    = D1;
            for (int i = 0; i < 40 && !done; i++) begin
                @(negedge clk);
                if (bus_error) pulses++;
                if (ibus_stall) begin
                    stalls++;
                end else begin
                    done = 1'b1;
                    chk("timeout.read_data", ibus_read_data, 32'h0);
                end
                @(posedge clk);
                #1;
            end
            chk("timeout.completed", {31'b0, done}, 32'h1);
            chk("timeout.stall_cycles", stalls, 9);
            chk("timeout.error_pulses", pulses, 1);
            ibus_read = 1'b0;
            @(negedge clk);
            chk("timeout.error_cleared", {31'b0, bus_error}, 32'h0);
            @(posedge clk);
            #1;
            step(mk(1, 0, A0, 4'hF, 0, 0, D1, 1, 0, 0, A0, 0, 0), "timeout_nobuf");
            step(mk(1, 0, A0, 4'hF, 0, 0, D1, 1, 1, 0, A0, 0, 0), "timeout_nobuf2");
            step(mk(1, 0, A0, 4'hF, 0, 0, 0,  0, 0, 0, A0, 1, D1), "timeout_nobuf3");
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
